// File: rtl/fp_compare_pipe.sv
// Two-stage floating-point compare / min-max / classify unit with valid-ready handshake.
// Optional NaN-boxing of single operands (FLEN=64 only) is enabled by defining FP_COMPARE_NANBOX_EN.
`timescale 1ns/1ps
module fp_compare_pipe #(
  parameter int FLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FLEN-1:0]  operand_a,
  input  logic [FLEN-1:0]  operand_b,
  input  logic             fmt,
  input  logic [2:0]       operation,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FLEN-1:0]  result,
  output logic             flag_nv,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0]  OP_FEQ    = 3'b000;
  localparam logic [2:0]  OP_FLT    = 3'b001;
  localparam logic [2:0]  OP_FLE    = 3'b010;
  localparam logic [2:0]  OP_FMIN   = 3'b011;
  localparam logic [2:0]  OP_FMAX   = 3'b100;
  localparam logic [2:0]  OP_FCLASS = 3'b101;
  localparam logic [63:0] QNAN_S    = 64'h0000_0000_7FC0_0000;
  localparam logic [63:0] QNAN_D    = 64'h7FF8_0000_0000_0000;
  localparam logic        IS64      = (FLEN == 64);
`ifdef FP_COMPARE_NANBOX_EN
  localparam logic        BOX_EN    = IS64;
`else
  localparam logic        BOX_EN    = 1'b0;
`endif

  // One-hot class mask: bit0 -inf .. bit7 +inf, bit8 sNaN, bit9 qNaN.
  function automatic logic [9:0] classify(input logic [63:0] v, input logic dbl);
    logic sign, exp_ones, exp_zero, man_zero, quiet;
    logic [9:0] mask;
    if (dbl) begin
      sign = v[63]; exp_ones = &v[62:52]; exp_zero = ~|v[62:52];
      man_zero = ~|v[51:0]; quiet = v[51];
    end else begin
      sign = v[31]; exp_ones = &v[30:23]; exp_zero = ~|v[30:23];
      man_zero = ~|v[22:0]; quiet = v[22];
    end
    if (exp_ones && man_zero)      mask = sign ? 10'b00_0000_0001 : 10'b00_1000_0000;
    else if (exp_ones)             mask = quiet ? 10'b10_0000_0000 : 10'b01_0000_0000;
    else if (exp_zero && man_zero) mask = sign ? 10'b00_0000_1000 : 10'b00_0001_0000;
    else if (exp_zero)             mask = sign ? 10'b00_0000_0100 : 10'b00_0010_0000;
    else                           mask = sign ? 10'b00_0000_0010 : 10'b00_0100_0000;
    return mask;
  endfunction

  // A single operand that is not properly boxed reads as the canonical qNaN.
  function automatic logic [63:0] unbox(input logic [63:0] v, input logic dbl);
    logic [63:0] r;
    if (dbl)                                        r = v;
    else if (BOX_EN && (v[63:32] != 32'hFFFF_FFFF)) r = QNAN_S;
    else                                            r = {32'h0000_0000, v[31:0]};
    return r;
  endfunction

  function automatic logic [63:0] box(input logic [31:0] low);
    logic [63:0] r;
    if (BOX_EN) r = {32'hFFFF_FFFF, low};
    else        r = {32'h0000_0000, low};
    return r;
  endfunction

  logic        advance_s;
  logic        dbl_s;
  logic [63:0] a_dec_s, b_dec_s;

  logic             s1_valid_r;
  logic [2:0]       s1_op_r;
  logic [TAG_W-1:0] s1_tag_r;
  logic             s1_dbl_r;
  logic [63:0]      s1_a_r, s1_b_r;
  logic [9:0]       s1_cls_a_r, s1_cls_b_r;

  logic        sign_a_s, sign_b_s, nan_a_s, nan_b_s, snan_s, zero_both_s;
  logic        eq_s, lt_s, pick_a_s;
  logic [62:0] mag_a_s, mag_b_s;
  logic [63:0] mm_s, res_s;
  logic        nv_s;

  assign advance_s = !out_valid | out_ready;
  assign in_ready  = advance_s;

  // Front end: format select and NaN-box check ahead of the S1 register.
  always_comb begin
    dbl_s   = IS64 ? fmt : 1'b0;
    a_dec_s = unbox(64'(operand_a), dbl_s);
    b_dec_s = unbox(64'(operand_b), dbl_s);
  end

  // S1: decoded operands with their class masks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_r <= 1'b0;
      s1_op_r    <= 3'b000;
      s1_tag_r   <= '0;
      s1_dbl_r   <= 1'b0;
      s1_a_r     <= 64'h0;
      s1_b_r     <= 64'h0;
      s1_cls_a_r <= 10'h000;
      s1_cls_b_r <= 10'h000;
    end else if (flush) begin
      s1_valid_r <= 1'b0;
    end else if (advance_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_op_r    <= operation;
        s1_tag_r   <= in_tag;
        s1_dbl_r   <= dbl_s;
        s1_a_r     <= a_dec_s;
        s1_b_r     <= b_dec_s;
        s1_cls_a_r <= classify(a_dec_s, dbl_s);
        s1_cls_b_r <= classify(b_dec_s, dbl_s);
      end
    end
  end

  // Sign-magnitude ordering and result selection from S1 contents.
  always_comb begin
    sign_a_s    = s1_dbl_r ? s1_a_r[63] : s1_a_r[31];
    sign_b_s    = s1_dbl_r ? s1_b_r[63] : s1_b_r[31];
    mag_a_s     = s1_dbl_r ? s1_a_r[62:0] : {32'h0000_0000, s1_a_r[30:0]};
    mag_b_s     = s1_dbl_r ? s1_b_r[62:0] : {32'h0000_0000, s1_b_r[30:0]};
    nan_a_s     = |s1_cls_a_r[9:8];
    nan_b_s     = |s1_cls_b_r[9:8];
    snan_s      = s1_cls_a_r[8] | s1_cls_b_r[8];
    zero_both_s = (|s1_cls_a_r[4:3]) & (|s1_cls_b_r[4:3]);
    eq_s        = zero_both_s | ((mag_a_s == mag_b_s) && (sign_a_s == sign_b_s));
    if (zero_both_s)               lt_s = 1'b0;
    else if (sign_a_s != sign_b_s) lt_s = sign_a_s;
    else if (sign_a_s)             lt_s = mag_a_s > mag_b_s;
    else                           lt_s = mag_a_s < mag_b_s;

    // On equal values the sign breaks the tie so that -0 < +0 for min/max only.
    if (s1_op_r == OP_FMIN) pick_a_s = lt_s | (eq_s & sign_a_s);
    else                    pick_a_s = (!lt_s & !eq_s) | (eq_s & !sign_a_s);

    if (nan_a_s && nan_b_s) mm_s = s1_dbl_r ? QNAN_D : QNAN_S;
    else if (nan_a_s)       mm_s = s1_b_r;
    else if (nan_b_s)       mm_s = s1_a_r;
    else                    mm_s = pick_a_s ? s1_a_r : s1_b_r;
    if (!s1_dbl_r) mm_s = box(mm_s[31:0]);
    else           mm_s = mm_s;

    res_s = 64'h0;
    nv_s  = 1'b0;
    case (s1_op_r)
      OP_FEQ: begin
        res_s = {63'h0, !nan_a_s && !nan_b_s && eq_s};
        nv_s  = snan_s;
      end
      OP_FLT: begin
        res_s = {63'h0, !nan_a_s && !nan_b_s && lt_s};
        nv_s  = nan_a_s | nan_b_s;
      end
      OP_FLE: begin
        res_s = {63'h0, !nan_a_s && !nan_b_s && (lt_s || eq_s)};
        nv_s  = nan_a_s | nan_b_s;
      end
      OP_FMIN, OP_FMAX: begin
        res_s = mm_s;
        nv_s  = snan_s;
      end
      OP_FCLASS: begin
        res_s = {54'h0, s1_cls_a_r};
        nv_s  = 1'b0;
      end
      default: begin
        res_s = 64'h0;
        nv_s  = 1'b0;
      end
    endcase
  end

  // S2: registered outputs, held while the consumer stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flag_nv   <= 1'b0;
      out_tag   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (advance_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        result  <= FLEN'(res_s);
        flag_nv <= nv_s;
        out_tag <= s1_tag_r;
      end
    end
  end

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Self-checking bench: a 32-bit and a 64-bit instance share the handshake; a queue-based
// reference model computes expectations from IEEE class rules and integer ordering keys.
`timescale 1ns/1ps
module tb_fp_compare_pipe;

`ifdef FP_COMPARE_NANBOX_EN
  localparam bit BOXEN = 1'b1;
`else
  localparam bit BOXEN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, flush, in_valid, fmt, out_ready;
  logic [2:0]  operation;
  logic [4:0]  in_tag;
  logic [31:0] a32, b32;
  logic [63:0] a64, b64;
  logic        ir32, ov32, nv32, ir64, ov64, nv64;
  logic [31:0] res32;
  logic [63:0] res64;
  logic [4:0]  tag32, tag64;

  fp_compare_pipe #(.FLEN(32), .TAG_W(5)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(ir32),
    .operand_a(a32), .operand_b(b32), .fmt(fmt), .operation(operation), .in_tag(in_tag),
    .out_valid(ov32), .out_ready(out_ready), .result(res32), .flag_nv(nv32), .out_tag(tag32));

  fp_compare_pipe #(.FLEN(64), .TAG_W(5)) u_dut64 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(ir64),
    .operand_a(a64), .operand_b(b64), .fmt(fmt), .operation(operation), .in_tag(in_tag),
    .out_valid(ov64), .out_ready(out_ready), .result(res64), .flag_nv(nv64), .out_tag(tag64));

  int n_cmp = 0;
  int n_err = 0;
  logic [4:0] tag_cnt = 5'd0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [9:0] m_class(input logic [63:0] v, input bit dbl);
    int mw = dbl ? 52 : 23;
    int ew = dbl ? 11 : 8;
    logic [63:0] man  = v & ((64'd1 << mw) - 64'd1);
    logic [63:0] ex   = (v >> mw) & ((64'd1 << ew) - 64'd1);
    logic [63:0] emax = (64'd1 << ew) - 64'd1;
    bit neg = v[mw + ew];
    int idx;
    if (ex == emax)   idx = (man == 64'd0) ? (neg ? 0 : 7) : (man[mw-1] ? 9 : 8);
    else if (ex == 0) idx = (man == 64'd0) ? (neg ? 3 : 4) : (neg ? 2 : 5);
    else              idx = neg ? 1 : 6;
    return 10'd1 << idx;
  endfunction

  // Signed integer key: -0 and +0 collapse to 0, order follows the real value.
  function automatic longint m_key(input logic [63:0] v, input bit dbl);
    int w = dbl ? 63 : 31;
    longint mag = longint'(v & ((64'd1 << w) - 64'd1));
    return v[w] ? -mag : mag;
  endfunction

  function automatic logic [64:0] model(input logic [2:0] op, input logic [63:0] a_in,
                                        input logic [63:0] b_in, input bit dbl, input bit boxen);
    logic [63:0] a = a_in;
    logic [63:0] b = b_in;
    logic [63:0] r = 64'd0;
    bit nv = 1'b0;
    logic [9:0] ca, cb;
    bit an, bn, sa;
    longint ka, kb;
    if (!dbl) begin
      a = (boxen && a_in[63:32] != 32'hFFFF_FFFF) ? 64'h7FC0_0000 : {32'd0, a_in[31:0]};
      b = (boxen && b_in[63:32] != 32'hFFFF_FFFF) ? 64'h7FC0_0000 : {32'd0, b_in[31:0]};
    end
    ca = m_class(a, dbl); cb = m_class(b, dbl);
    an = ca[9] | ca[8];   bn = cb[9] | cb[8];
    ka = m_key(a, dbl);   kb = m_key(b, dbl);
    sa = dbl ? a[63] : a[31];
    case (op)
      3'd0: begin r = {63'd0, !an && !bn && ka == kb}; nv = ca[8] | cb[8]; end
      3'd1: begin r = {63'd0, !an && !bn && ka <  kb}; nv = an | bn; end
      3'd2: begin r = {63'd0, !an && !bn && ka <= kb}; nv = an | bn; end
      3'd3, 3'd4: begin
        if (an && bn)     r = dbl ? 64'h7FF8_0000_0000_0000 : 64'h7FC0_0000;
        else if (an)      r = b;
        else if (bn)      r = a;
        else if (op == 3'd3) r = (ka < kb || (ka == kb && sa))  ? a : b;
        else                 r = (ka > kb || (ka == kb && !sa)) ? a : b;
        if (!dbl) r = boxen ? {32'hFFFF_FFFF, r[31:0]} : {32'd0, r[31:0]};
        nv = ca[8] | cb[8];
      end
      3'd5: r = {54'd0, ca};
      default: r = 64'd0;
    endcase
    return {nv, r};
  endfunction

  function automatic logic [63:0] gen_val(input bit dbl);
    int mw = dbl ? 52 : 23;
    int ew = dbl ? 11 : 8;
    logic [63:0] emax = (64'd1 << ew) - 64'd1;
    logic [63:0] man  = {$urandom, $urandom} & ((64'd1 << mw) - 64'd1);
    logic [63:0] ex   = {$urandom, $urandom} & emax;
    logic [63:0] sgn  = 64'($urandom_range(0, 1));
    case ($urandom_range(0, 7))
      0: begin ex = 64'd0; man = 64'd0; end
      1: begin ex = emax;  man = 64'd0; end
      2: begin ex = emax;  man = man | (64'd1 << (mw - 1)); end
      3: begin ex = emax;  man = (man & ~(64'd1 << (mw - 1))) | 64'd1; end
      4: begin ex = 64'd0; man = man | 64'd1; end
      5: begin ex = (emax >> 1) + 64'($urandom_range(0, 2)); man = man & 64'd7; end
      default: ;
    endcase
    return (sgn << (mw + ew)) | (ex << mw) | man;
  endfunction

  // ---------------- scoreboard monitor ----------------
  typedef struct { logic [4:0] tag; logic [64:0] e32; logic [64:0] e64; } exp_t;
  exp_t q[$];
  bit hold = 1'b0;
  logic [31:0] h_res32; logic [63:0] h_res64; logic h_nv32; logic [4:0] h_tag;

  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      hold = 1'b0;
    end else begin
      exp_t e;
      if (hold) begin
        check_val("hold_valid", 64'(ov32), 64'd1);
        check_val("hold_res32", 64'(res32), 64'(h_res32));
        check_val("hold_res64", res64, h_res64);
        check_val("hold_nv32", 64'(nv32), 64'(h_nv32));
        check_val("hold_tag", 64'(tag32), 64'(h_tag));
      end
      check_val("in_ready", 64'(ir32), 64'(!ov32 || out_ready));
      check_val("ready64", 64'(ir64), 64'(ir32));
      check_val("valid64", 64'(ov64), 64'(ov32));
      if (flush) begin
        q.delete();
      end else begin
        if (ov32 && out_ready) begin
          if (q.size() == 0) begin
            check_val("spurious_out", 64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            check_val("tag", 64'(tag32), 64'(e.tag));
            check_val("tag64", 64'(tag64), 64'(e.tag));
            check_val("res32", 64'(res32), {32'd0, e.e32[31:0]});
            check_val("nv32", 64'(nv32), 64'(e.e32[64]));
            check_val("res64", res64, e.e64[63:0]);
            check_val("nv64", 64'(nv64), 64'(e.e64[64]));
          end
        end
        if (in_valid && ir32) begin
          e.tag = in_tag;
          e.e32 = model(operation, {32'd0, a32}, {32'd0, b32}, 1'b0, 1'b0);
          e.e64 = model(operation, a64, b64, fmt, BOXEN);
          q.push_back(e);
        end
      end
      hold = ov32 && !out_ready && !flush;
      h_res32 = res32; h_res64 = res64; h_nv32 = nv32; h_tag = tag32;
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic f);
    operation = op; a64 = a; b64 = b; a32 = a[31:0]; b32 = b[31:0]; fmt = f;
    in_tag = tag_cnt; tag_cnt++; in_valid = 1'b1;
  endtask

  // Issues one operation with out_ready=1 and checks the two-cycle latency.
  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic f);
    logic [4:0] t;
    out_ready = 1'b1; flush = 1'b0;
    set_op(op, a, b, f);
    t = in_tag;
    @(negedge clk); check_val("issue_ready", 64'(ir32), 64'd1);
    @(posedge clk); #1; in_valid = 1'b0;
    check_val("lat1_valid", 64'(ov32), 64'd0);
    @(posedge clk); #1;
    check_val("lat2_valid", 64'(ov32), 64'd1);
    check_val("lat2_tag", 64'(tag32), 64'(t));
  endtask

  task automatic directed(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic en);
    issue(op, {32'hFFFF_FFFF, a}, {32'hFFFF_FFFF, b}, 1'b0);
    check_val({name, "_res"}, 64'(res32), 64'(er));
    check_val({name, "_nv"}, 64'(nv32), 64'(en));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] t;
    bit acc;
    int n, cyc;
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; fmt = 1'b0; out_ready = 1'b1;
    operation = 3'd0; in_tag = 5'd0; a32 = 32'd0; b32 = 32'd0; a64 = 64'd0; b64 = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_valid", 64'(ov32), 64'd0);
    check_val("rst_res", 64'(res32), 64'd0);
    check_val("rst_nv", 64'(nv32), 64'd0);
    check_val("rst_tag", 64'(tag32), 64'd0);
    check_val("rst_res64", res64, 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_val("post_rst_ready", 64'(ir32), 64'd1);

    directed("feq_one",   3'd0, 32'h3F80_0000, 32'h3F80_0000, 32'd1, 1'b0);
    directed("flt_snan",  3'd1, 32'h7F80_0001, 32'h3F80_0000, 32'd0, 1'b1);
    directed("feq_snan",  3'd0, 32'h7F80_0001, 32'h3F80_0000, 32'd0, 1'b1);
    directed("feq_qnan",  3'd0, 32'h7FC0_0000, 32'h7FC0_0000, 32'd0, 1'b0);
    directed("fmin_zero", 3'd3, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0);
    directed("fmax_zero", 3'd4, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
    directed("fmax_qnan", 3'd4, 32'h7FC0_0000, 32'h7FC0_0000, 32'h7FC0_0000, 1'b0);
    directed("fmax_snan", 3'd4, 32'h7F80_0001, 32'h4000_0000, 32'h4000_0000, 1'b1);
    directed("fclass_sub", 3'd5, 32'h0000_0001, 32'h0, 32'h20, 1'b0);
    directed("fclass_ninf", 3'd5, 32'hFF80_0000, 32'h0, 32'h001, 1'b0);
    directed("flt_zeros", 3'd1, 32'h8000_0000, 32'h0000_0000, 32'd0, 1'b0);
    directed("fle_zeros", 3'd2, 32'h0000_0000, 32'h8000_0000, 32'd1, 1'b0);
    directed("flt_neg",   3'd1, 32'hC000_0000, 32'hBF80_0000, 32'd1, 1'b0);
    directed("reserved",  3'd7, 32'h3F80_0000, 32'h3F80_0000, 32'd0, 1'b0);

    issue(3'd0, 64'h0000_0000_3F80_0000, 64'hFFFF_FFFF_3F80_0000, 1'b0);
    check_val("nanbox_feq64", res64, BOXEN ? 64'd0 : 64'd1);
    issue(3'd3, 64'hBFF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b1);
    check_val("fmin_dbl", res64, 64'hBFF0_0000_0000_0000);

    // Back-to-back stream of four with a three-cycle consumer stall.
    n = 0; cyc = 0;
    while (n < 4 && cyc < 40) begin
      set_op(3'(n), {32'hFFFF_FFFF, 32'h3F80_0000}, {32'hFFFF_FFFF, 32'h4000_0000}, 1'b0);
      in_tag = 5'(16 + n);
      out_ready = !(cyc >= 2 && cyc < 5);
      @(negedge clk);
      acc = ir32;
      if (cyc >= 2 && cyc < 5) check_val("stall_ready", 64'(ir32), 64'd0);
      @(posedge clk); #1;
      if (acc) n++;
      cyc++;
    end
    check_val("stream_accepted", 64'(n), 64'd4);
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
    check_val("stream_drain", 64'(q.size()), 64'd0);

    // Flush with two operations in flight plus one presented in the flush cycle.
    issue(3'd0, 64'd0, 64'd0, 1'b0);
    set_op(3'd1, 64'd0, 64'd0, 1'b0); @(posedge clk); #1;
    set_op(3'd2, 64'd0, 64'd0, 1'b0); @(posedge clk); #1;
    flush = 1'b1; set_op(3'd4, 64'd0, 64'd0, 1'b0); @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_val("post_flush_valid", 64'(ov32), 64'd0);
      @(posedge clk); #1;
    end

    // Reset pulse mid-stream.
    for (int i = 0; i < 3; i++) begin
      set_op(3'(i), 64'h3F80_0000, 64'h3F80_0000, 1'b0); @(posedge clk); #1;
    end
    #2 reset_n = 1'b0; #1;
    check_val("midrst_valid", 64'(ov32), 64'd0);
    check_val("midrst_res", 64'(res32), 64'd0);
    check_val("midrst_tag", 64'(tag32), 64'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    check_val("midrst_ready", 64'(ir32), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_val("post_rst_valid", 64'(ov32 | ov64), 64'd0);
    end

    // Randomized traffic with back-pressure and occasional flushes.
    for (int c = 0; c < 3000; c++) begin
      int sel;
      in_valid = ($urandom_range(0, 9) < 7);
      sel = $urandom_range(0, 15);
      operation = (sel > 7) ? 3'(sel % 6) : 3'(sel);
      fmt = 1'($urandom_range(0, 1));
      t = gen_val(1'b0); a32 = t[31:0];
      sel = $urandom_range(0, 9);
      t = gen_val(1'b0);
      b32 = (sel < 3) ? a32 : (sel == 3) ? (a32 ^ 32'h8000_0000) : t[31:0];
      if (fmt) a64 = gen_val(1'b1);
      else begin
        t = gen_val(1'b0);
        a64 = {($urandom_range(0, 7) == 0) ? $urandom : 32'hFFFF_FFFF, t[31:0]};
      end
      if (sel < 3) b64 = a64;
      else if (sel == 3) b64 = a64 ^ (fmt ? 64'h8000_0000_0000_0000 : 64'h8000_0000);
      else if (fmt) b64 = gen_val(1'b1);
      else begin
        t = gen_val(1'b0);
        b64 = {($urandom_range(0, 7) == 0) ? $urandom : 32'hFFFF_FFFF, t[31:0]};
      end
      in_tag = 5'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 39) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
    check_val("final_drain", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
    check_val("final_idle", 64'(ov32), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
